// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS execute stage: bundle layouts, ALU encodings
// and multiplier FSM states.
package mips_pkg;

  localparam int unsigned ID_EX_W  = 144;
  localparam int unsigned EX_MEM_W = 107;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_ORI   = 2'b11
  } aluop_e;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_BUSY = 2'd1,
    MS_DONE = 2'd2
  } mult_state_e;

  // Field order matches the bundle bit layout, MSB first.
  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic        regdst;
    aluop_e      aluop;
    logic        alusrc;
    logic [31:0] npc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rt;
    logic [1:0]  rsvd;
  } id_ex_t;

  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] btarget;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] rd2;
    logic [4:0]  wreg;
  } ex_mem_t;

endpackage

// File: rtl/execute_stage_mult_unit.sv
// Iterative shift-add HI/LO multiplier. busy is the combinational stall request
// covering the issue cycle and every BUSY cycle.
module mult_unit
  import mips_pkg::*;
#(
  parameter int unsigned MULT_BPC = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MULT_ITER = 32 / MULT_BPC;
  localparam int unsigned CNT_W     = (MULT_ITER > 1) ? $clog2(MULT_ITER) : 1;

  mult_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0] mcand_q, mcand_d, acc_q, acc_d;
  logic [31:0] mplier_q, mplier_d, hi_q, hi_d, lo_q, lo_d;
  logic        neg_q, neg_d;

  assign busy = !reset && !flush &&
                ((state_q == MS_BUSY) || (state_q == MS_IDLE && start));
  assign hi = hi_q;
  assign lo = lo_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      MS_IDLE: begin
        if (start) begin
          state_d  = MS_BUSY;
          cnt_d    = '0;
          neg_d    = is_signed && (a[31] ^ b[31]);
          mcand_d  = {32'h0, (is_signed && a[31]) ? (~a + 32'd1) : a};
          mplier_d = (is_signed && b[31]) ? (~b + 32'd1) : b;
          acc_d    = '0;
        end
      end
      MS_BUSY: begin
        for (int unsigned i = 0; i < MULT_BPC; i++) begin
          if (mplier_d[0]) acc_d = acc_d + mcand_d;
          mcand_d  = mcand_d << 1;
          mplier_d = mplier_d >> 1;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MULT_ITER - 1)) state_d = MS_DONE;
      end
      MS_DONE: begin
        {hi_d, lo_d} = neg_q ? (~acc_q + 64'd1) : acc_q;
        state_d      = MS_IDLE;
      end
      default: state_d = MS_IDLE;
    endcase
    // A squash abandons the operation wherever it is and leaves HI/LO alone.
    if (flush) begin
      state_d = MS_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= MS_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// MIPS EX stage: ALU, branch-target adder, write-register mux and EX/MEM
// register, with the HI/LO multiplier stalling upstream while it iterates.
module execute_stage
  import mips_pkg::*;
#(
  parameter int unsigned MULT_BPC = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic [ID_EX_W-1:0]  id_ex_bundle,
  output logic                stall,
  output logic [EX_MEM_W-1:0] ex_mem_bundle
);

  id_ex_t      idx;
  ex_mem_t     ex_mem_q, ex_mem_d;
  logic [31:0] op_b, alu_result, hi, lo;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic        is_mult, unused_rsvd;

  assign idx         = id_ex_t'(id_ex_bundle);
  assign unused_rsvd = ^idx.rsvd;
  assign shamt       = idx.imm[10:6];
  assign funct       = idx.imm[5:0];
  assign op_b        = idx.alusrc ? idx.imm : idx.rd2;
  assign is_mult     = (idx.aluop == ALUOP_FUNCT) && (funct == F_MULT || funct == F_MULTU);

  mult_unit #(.MULT_BPC(MULT_BPC)) u_mult (
    .clk       (clk),
    .reset     (reset),
    .start     (is_mult),
    .is_signed (funct == F_MULT),
    .a         (idx.rd1),
    .b         (op_b),
    .flush     (flush),
    .busy      (stall),
    .hi        (hi),
    .lo        (lo)
  );

  always_comb begin
    alu_result = '0;
    case (idx.aluop)
      ALUOP_ADD: alu_result = idx.rd1 + op_b;
      ALUOP_SUB: alu_result = idx.rd1 - op_b;
      ALUOP_ORI: alu_result = idx.rd1 | {16'h0, idx.imm[15:0]};
      default: begin
        case (funct)
          F_ADD, F_ADDU: alu_result = idx.rd1 + op_b;
          F_SUB, F_SUBU: alu_result = idx.rd1 - op_b;
          F_AND:  alu_result = idx.rd1 & op_b;
          F_OR:   alu_result = idx.rd1 | op_b;
          F_XOR:  alu_result = idx.rd1 ^ op_b;
          F_NOR:  alu_result = ~(idx.rd1 | op_b);
          F_SLT:  alu_result = {31'h0, $signed(idx.rd1) < $signed(op_b)};
          F_SLTU: alu_result = {31'h0, idx.rd1 < op_b};
          F_SLL:  alu_result = idx.rd2 << shamt;
          F_SRL:  alu_result = idx.rd2 >> shamt;
          F_SRA:  alu_result = $unsigned($signed(idx.rd2) >>> shamt);
          F_MFHI: alu_result = hi;
          F_MFLO: alu_result = lo;
          default: alu_result = '0;
        endcase
      end
    endcase
  end

  // Mult/multu never write back, so they leave EX as a bubble like a stall or squash.
  always_comb begin
    ex_mem_d = '0;
    if (!(flush || stall || is_mult)) begin
      ex_mem_d.wb         = idx.wb;
      ex_mem_d.m          = idx.m;
      ex_mem_d.btarget    = idx.npc + (idx.imm << 2);
      ex_mem_d.zero       = ((idx.rd1 - op_b) == 32'h0);
      ex_mem_d.alu_result = alu_result;
      ex_mem_d.rd2        = idx.rd2;
      ex_mem_d.wreg       = idx.regdst ? idx.imm[15:11] : idx.rt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ex_mem_q <= '0;
    else       ex_mem_q <= ex_mem_d;
  end

  assign ex_mem_bundle = ex_mem_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed-vector bench for execute_stage with MULT_BPC=1.
module tb_execute_stage;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic [143:0] id_ex_bundle = '0;
  logic         stall;
  logic [106:0] ex_mem_bundle;

  int vectors = 0;
  int miscompares = 0;

  execute_stage #(.MULT_BPC(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .id_ex_bundle  (id_ex_bundle),
    .stall         (stall),
    .ex_mem_bundle (ex_mem_bundle)
  );

  always #5 clk = ~clk;

  function automatic logic [143:0] mk(input logic [1:0] wb, input logic [2:0] m,
                                      input logic regdst, input logic [1:0] aluop,
                                      input logic alusrc, input logic [31:0] npc,
                                      input logic [31:0] rd1, input logic [31:0] rd2,
                                      input logic [31:0] imm, input logic [4:0] rt);
    return {wb, m, regdst, aluop, alusrc, npc, rd1, rd2, imm, rt, 2'b00};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {16'h0, rd, sh, fn};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    id_ex_bundle = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (ex_mem_bundle !== 107'h0) begin
      miscompares++;
      $display("FAIL reset_bundle got %h exp 0", ex_mem_bundle);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_stall got %b exp 0", stall);
    end
  endtask

  task automatic test_add();
    id_ex_bundle = mk(2'b10, 3'b000, 1'b1, 2'b10, 1'b0, 32'h0, 32'd5, 32'd7,
                      rtype(5'd3, 5'd0, 6'h20), 5'd9);
    tick();
    vectors++;
    if (ex_mem_bundle[68:37] !== 32'd12) begin
      miscompares++;
      $display("FAIL add_result got %h exp %h", ex_mem_bundle[68:37], 32'd12);
    end
    vectors++;
    if (ex_mem_bundle[4:0] !== 5'd3) begin
      miscompares++;
      $display("FAIL add_wreg got %0d exp 3", ex_mem_bundle[4:0]);
    end
    vectors++;
    if (ex_mem_bundle[106:102] !== 5'b10000) begin
      miscompares++;
      $display("FAIL add_wb_m got %b exp 10000", ex_mem_bundle[106:102]);
    end
    vectors++;
    if ({ex_mem_bundle[69], ex_mem_bundle[36:5]} !== {1'b0, 32'd7}) begin
      miscompares++;
      $display("FAIL add_zero_rd2 got %h exp %h", {ex_mem_bundle[69], ex_mem_bundle[36:5]},
               {1'b0, 32'd7});
    end
  endtask

  task automatic test_alu_table();
    logic [5:0]  fn [14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                             6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h3F};
    logic [31:0] ex [14] = '{32'hF0001333, 32'hF0001333, 32'hF0001135, 32'hF0001135,
                             32'h00000034, 32'hF00012FF, 32'hF00012CB, 32'h0FFFED00,
                             32'h00000000, 32'h00000001, 32'h00000FF0, 32'h0800000F,
                             32'hF800000F, 32'h00000000};
    for (int i = 0; i < 14; i++) begin
      id_ex_bundle = mk(2'b10, 3'b000, 1'b1, 2'b10, 1'b0, 32'h0, 32'h70001234,
                        32'h800000FF, rtype(5'd1, 5'd4, fn[i]), 5'd0);
      tick();
      vectors++;
      if (ex_mem_bundle[68:37] !== ex[i]) begin
        miscompares++;
        $display("FAIL alu_funct_%h got %h exp %h", fn[i], ex_mem_bundle[68:37], ex[i]);
      end
    end
    // ORI zero-extends the low half even though imm32 is sign-extended.
    id_ex_bundle = mk(2'b10, 3'b000, 1'b0, 2'b11, 1'b1, 32'h0, 32'h12340000, 32'h0,
                      32'hFFFF8001, 5'd6);
    tick();
    vectors++;
    if ({ex_mem_bundle[68:37], ex_mem_bundle[4:0]} !== {32'h12348001, 5'd6}) begin
      miscompares++;
      $display("FAIL ori got %h exp %h", {ex_mem_bundle[68:37], ex_mem_bundle[4:0]},
               {32'h12348001, 5'd6});
    end
    id_ex_bundle = mk(2'b11, 3'b010, 1'b0, 2'b00, 1'b1, 32'h0, 32'h00001000, 32'h0,
                      32'hFFFFFFF8, 5'd8);
    tick();
    vectors++;
    if ({ex_mem_bundle[106:102], ex_mem_bundle[68:37]} !== {5'b11010, 32'h00000FF8}) begin
      miscompares++;
      $display("FAIL lw_addr got %h exp %h", {ex_mem_bundle[106:102], ex_mem_bundle[68:37]},
               {5'b11010, 32'h00000FF8});
    end
  endtask

  task automatic test_branch();
    id_ex_bundle = mk(2'b00, 3'b100, 1'b0, 2'b01, 1'b0, 32'h100, 32'd9, 32'd9, 32'd4, 5'd2);
    tick();
    vectors++;
    if (ex_mem_bundle[69] !== 1'b1) begin
      miscompares++;
      $display("FAIL beq_zero got %b exp 1", ex_mem_bundle[69]);
    end
    vectors++;
    if (ex_mem_bundle[101:70] !== 32'h110) begin
      miscompares++;
      $display("FAIL beq_btarget got %h exp 00000110", ex_mem_bundle[101:70]);
    end
    id_ex_bundle = mk(2'b00, 3'b100, 1'b0, 2'b01, 1'b0, 32'h100, 32'd9, 32'd8,
                      32'hFFFFFFFC, 5'd2);
    tick();
    vectors++;
    if ({ex_mem_bundle[101:70], ex_mem_bundle[69], ex_mem_bundle[68:37]}
        !== {32'h000000F0, 1'b0, 32'd1}) begin
      miscompares++;
      $display("FAIL beq_back got %h exp %h",
               {ex_mem_bundle[101:70], ex_mem_bundle[69], ex_mem_bundle[68:37]},
               {32'h000000F0, 1'b0, 32'd1});
    end
  endtask

  task automatic test_mult();
    int cycles = 0;
    id_ex_bundle = mk(2'b11, 3'b111, 1'b1, 2'b10, 1'b0, 32'h0, 32'hFFFFFFFD, 32'd7,
                      rtype(5'd0, 5'd0, 6'h18), 5'd0);
    #1;
    while (stall === 1'b1 && cycles < 100) begin
      tick();
      cycles++;
      vectors++;
      if (ex_mem_bundle !== 107'h0) begin
        miscompares++;
        $display("FAIL mult_bubble cycle %0d got %h exp 0", cycles, ex_mem_bundle);
      end
    end
    vectors++;
    if (cycles != 33) begin
      miscompares++;
      $display("FAIL mult_stall_len got %0d exp 33", cycles);
    end
    tick();
    id_ex_bundle = mk(2'b10, 3'b000, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0,
                      rtype(5'd4, 5'd0, 6'h10), 5'd0);
    #1;
    vectors++;
    if ({stall, ex_mem_bundle} !== 108'h0) begin
      miscompares++;
      $display("FAIL mult_retire got %h exp 0", {stall, ex_mem_bundle});
    end
    tick();
    vectors++;
    if (ex_mem_bundle[68:37] !== 32'hFFFFFFFF) begin
      miscompares++;
      $display("FAIL mfhi got %h exp FFFFFFFF", ex_mem_bundle[68:37]);
    end
    id_ex_bundle = mk(2'b10, 3'b000, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0,
                      rtype(5'd5, 5'd0, 6'h12), 5'd0);
    tick();
    vectors++;
    if (ex_mem_bundle[68:37] !== 32'hFFFFFFEB) begin
      miscompares++;
      $display("FAIL mflo got %h exp FFFFFFEB", ex_mem_bundle[68:37]);
    end
  endtask

  task automatic test_flush();
    id_ex_bundle = mk(2'b11, 3'b000, 1'b1, 2'b10, 1'b0, 32'h0, 32'd1, 32'd1,
                      rtype(5'd7, 5'd0, 6'h20), 5'd0);
    flush = 1'b1;
    tick();
    vectors++;
    if (ex_mem_bundle !== 107'h0) begin
      miscompares++;
      $display("FAIL flush_alu got %h exp 0", ex_mem_bundle);
    end
    flush = 1'b0;
    id_ex_bundle = mk(2'b00, 3'b000, 1'b0, 2'b10, 1'b0, 32'h0, 32'hFFFFFFFF, 32'd2,
                      rtype(5'd0, 5'd0, 6'h19), 5'd0);
    repeat (11) tick();
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++;
      $display("FAIL multu_busy got %b exp 1", stall);
    end
    flush = 1'b1;
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_stall got %b exp 0", stall);
    end
    tick();
    flush = 1'b0;
    vectors++;
    if (ex_mem_bundle !== 107'h0) begin
      miscompares++;
      $display("FAIL flush_bubble got %h exp 0", ex_mem_bundle);
    end
    id_ex_bundle = mk(2'b10, 3'b000, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0,
                      rtype(5'd5, 5'd0, 6'h12), 5'd0);
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_idle got %b exp 0", stall);
    end
    tick();
    vectors++;
    if (ex_mem_bundle[68:37] !== 32'hFFFFFFEB) begin
      miscompares++;
      $display("FAIL flush_lo_kept got %h exp FFFFFFEB", ex_mem_bundle[68:37]);
    end
  endtask

  task automatic test_reset_mid_mult();
    id_ex_bundle = mk(2'b00, 3'b000, 1'b0, 2'b10, 1'b0, 32'h0, 32'hFFFFFFFD, 32'd7,
                      rtype(5'd0, 5'd0, 6'h18), 5'd0);
    repeat (5) tick();
    reset = 1'b1;
    #1;
    vectors++;
    if ({stall, ex_mem_bundle} !== 108'h0) begin
      miscompares++;
      $display("FAIL reset_async got %h exp 0", {stall, ex_mem_bundle});
    end
    id_ex_bundle = mk(2'b10, 3'b000, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0,
                      rtype(5'd5, 5'd0, 6'h10), 5'd0);
    tick();
    reset = 1'b0;
    tick();
    vectors++;
    if (ex_mem_bundle[68:37] !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_hi_clear got %h exp 0", ex_mem_bundle[68:37]);
    end
    id_ex_bundle = mk(2'b10, 3'b000, 1'b1, 2'b10, 1'b0, 32'h0, 32'hFFFFFFFF, 32'd1,
                      rtype(5'd5, 5'd0, 6'h2A), 5'd0);
    tick();
    vectors++;
    if (ex_mem_bundle[68:37] !== 32'd1) begin
      miscompares++;
      $display("FAIL slt_neg got %h exp 1", ex_mem_bundle[68:37]);
    end
    id_ex_bundle = mk(2'b10, 3'b000, 1'b1, 2'b10, 1'b0, 32'h0, 32'hFFFFFFFF, 32'd1,
                      rtype(5'd5, 5'd0, 6'h2B), 5'd0);
    tick();
    vectors++;
    if (ex_mem_bundle[68:37] !== 32'd0) begin
      miscompares++;
      $display("FAIL sltu_neg got %h exp 0", ex_mem_bundle[68:37]);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_table();
    test_branch();
    test_mult();
    test_flush();
    test_reset_mid_mult();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
